icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  I-cache miss handler. Sits upstream of the icache data array and feeds its refill port (refresh, cacheline_new).
//  Detects a miss from the tag-compare hit vector and stalls fetch.
//  Fetches the line over an AXI4 read burst, assembles it, and writes it into the LRU-selected way.
//  Then releases the stall so fetch replays the request as a hit.
// PARAMETERS
//  LINE_W      64  cache line width in bits (= CACHELINE_WIDTH)
//  AXI_DATA_W  32  AXI R data width; BEATS = LINE_W/AXI_DATA_W, must be an integer >= 1
//  INDEX_W     6   set-index width (64 sets)
//  OFFSET_W    3   byte-offset width (8-byte line)
//  TAG_W       55  tag width = 64-INDEX_W-OFFSET_W
// PORTS
//  clk            in   1            clock
//  rst            in   1            synchronous, active-high reset
//  req_valid      in   1            fetch request valid (sram_e)
//  req_addr       in   64           fetch address {tag,index,offset}
//  hit            in   2            per-way hit from tag compare, same cycle as req
//  lru            in   1            victim way for req_addr's set (0=way0, 1=way1)
//  stall          out  1            hold fetch / PC
//  refresh        out  1            one-cycle refill write strobe to data+tag arrays
//  refill_way     out  1            way written on refresh
//  refill_index   out  INDEX_W      set written on refresh
//  refill_tag     out  TAG_W        tag written on refresh
//  cacheline_new  out  LINE_W       assembled line
//  fault          out  1            one-cycle pulse: refill failed (bus error / bad burst)
//  arvalid        out  1            AXI AR valid
//  arready        in   1            AXI AR ready
//  araddr         out  64           line-aligned address {tag,index,OFFSET_W'b0}
//  arlen          out  8            BEATS-1
//  arsize         out  3            log2(AXI_DATA_W/8)
//  arburst        out  2            2'b01 INCR
//  rvalid         in   1            AXI R valid
//  rready         out  1            AXI R ready
//  rdata          in   AXI_DATA_W   AXI R data
//  rresp          in   2            AXI R response
//  rlast          in   1            AXI R last
// BEHAVIOUR
//  - Reset: state=IDLE.
//    All outputs 0, except arlen/arsize/arburst, which are constants.
//    Line buffer, beat counter and error flag are cleared.
//  - miss = req_valid & ~|hit.
//    stall = (state!=IDLE) | (state==IDLE & miss); combinational.
//  - IDLE: on miss, latch tag/index/lru into regs, go AR. Otherwise stay; hits cost 0 extra cycles.
//  - AR: arvalid=1 with araddr stable until arready is sampled high; then go R.
//    arvalid never drops before the handshake.
//  - R: rready=1. Each beat with rvalid (beat_cnt=k) writes rdata into line bits [k*AXI_DATA_W +: AXI_DATA_W].
//    Beat 0 is the lowest word. beat_cnt then increments.
//    - rresp!=0 on any beat sets err.
//    - rlast on beat k != BEATS-1 sets err; the burst ends at that rlast.
//    - Exit to WR when rlast is accepted.
//    - rlast missing on beat BEATS-1 sets err; keep draining, ignore data, until rlast.
//  - WR (1 cycle): if !err, refresh=1 with refill_way=lru_r, refill_index, refill_tag and cacheline_new from regs.
//    If err, refresh=0 and fault=1 instead. Go DONE.
//  - DONE (1 cycle): stall=1 so the tag/data arrays see the new line.
//    Next state is IDLE; the replayed req then hits.
//    After a fault, the replay misses again, so fetch-side handling of fault is required.
//  - Miss-to-hit latency: 1 (AR, arready immediate) + BEATS (R, no gaps) + 1 (WR) + 1 (DONE); = 5 cycles for BEATS=2.
//  - req_addr/hit/lru are ignored outside IDLE. The latched address is used throughout the refill.
//  - Only one outstanding AR; no new miss is accepted until IDLE.
//  - rst in any state returns to IDLE next cycle and aborts the burst (the interconnect shares rst).
//    No refresh is issued for the aborted line.
//  - beat_cnt width $clog2(BEATS)+1; it saturates at BEATS, with no wrap.
// TESTING
//  1 hit=2'b01, req_valid=1 -> stall=0, arvalid never 1, refresh=0.
//  2 miss addr=0x8000_0048, lru=1, arready=1, rdata 0x11111111 then 0x22222222 (rlast on beat 1):
//    araddr=0x8000_0048, arlen=1, arsize=2, burst INCR.
//    refresh pulses once with way=1, index=9, line=0x22222222_11111111; stall drops 5 cycles after the miss.
//  3 arready held low 3 cycles -> arvalid/araddr stable for 4 cycles; refill completes; latency +3.
//  4 rvalid gaps (beat0, 2 idle, beat1) -> line correct; single refresh.
//  5 rresp=2'b10 on beat 0 -> refresh never asserted; fault=1 for exactly one cycle in WR; return to IDLE.
//  6 rst asserted during R after beat 0 -> next cycle IDLE; all outputs 0; no refresh; next miss refills correctly.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - fetch, refill-port and AXI read-channel bundle for the i-cache refill controller
interface icache_refill_ctrl_if #(
    parameter int LINE_W     = 64,
    parameter int AXI_DATA_W = 32,
    parameter int INDEX_W    = 6,
    parameter int TAG_W      = 55
);
    logic                  req_valid;
    logic [63:0]           req_addr;
    logic [1:0]            hit;
    logic                  lru;
    logic                  stall;
    logic                  refresh;
    logic                  refill_way;
    logic [INDEX_W-1:0]    refill_index;
    logic [TAG_W-1:0]      refill_tag;
    logic [LINE_W-1:0]     cacheline_new;
    logic                  fault;
    logic                  arvalid;
    logic                  arready;
    logic [63:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        input  req_valid, req_addr, hit, lru, arready, rvalid, rdata, rresp, rlast,
        output stall, refresh, refill_way, refill_index, refill_tag, cacheline_new, fault,
               arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport slave (
        output req_valid, req_addr, hit, lru, arready, rvalid, rdata, rresp, rlast,
        input  stall, refresh, refill_way, refill_index, refill_tag, cacheline_new, fault,
               arvalid, araddr, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - i-cache miss handler: stalls fetch, refills a line over an AXI4 read burst
module icache_refill_ctrl #(
    parameter int LINE_W     = 64,
    parameter int AXI_DATA_W = 32,
    parameter int INDEX_W    = 6,
    parameter int OFFSET_W   = 3,
    parameter int TAG_W      = 64 - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst,
    icache_refill_ctrl_if.master bus
);
    localparam int BEATS = LINE_W / AXI_DATA_W;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, AR, R, WR, DONE} state_t;

    state_t             state;
    logic [TAG_W-1:0]   tag_r;
    logic [INDEX_W-1:0] index_r;
    logic               lru_r;
    logic [LINE_W-1:0]  line_buf;
    logic [CNT_W-1:0]   beat_cnt;
    logic               err;
    logic               arvalid_r;
    logic               rready_r;
    logic               refresh_r;
    logic               fault_r;
    logic               miss;
    logic               last_slot;
    logic               beat_err;
    logic               burst_err;
    logic               unused_offset;

    assign miss      = bus.req_valid & ~|bus.hit;
    assign bus.stall = (state != IDLE) | miss;

    // A beat is bad if its response is an error or rlast disagrees with the expected final slot.
    assign last_slot = (beat_cnt == CNT_W'(BEATS - 1));
    assign beat_err  = (bus.rresp != 2'b00) | (bus.rlast != last_slot);
    assign burst_err = err | beat_err;

    assign bus.arvalid       = arvalid_r;
    assign bus.araddr        = {tag_r, index_r, {OFFSET_W{1'b0}}};
    assign bus.arlen         = 8'(BEATS - 1);
    assign bus.arsize        = 3'($clog2(AXI_DATA_W / 8));
    assign bus.arburst       = 2'b01;
    assign bus.rready        = rready_r;
    assign bus.refresh       = refresh_r;
    assign bus.fault         = fault_r;
    assign bus.refill_way    = lru_r;
    assign bus.refill_index  = index_r;
    assign bus.refill_tag    = tag_r;
    assign bus.cacheline_new = line_buf;
    assign unused_offset     = ^bus.req_addr[OFFSET_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag_r     <= '0;
            index_r   <= '0;
            lru_r     <= 1'b0;
            line_buf  <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            refresh_r <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            refresh_r <= 1'b0;
            fault_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss) begin
                        tag_r     <= bus.req_addr[63 -: TAG_W];
                        index_r   <= bus.req_addr[OFFSET_W +: INDEX_W];
                        lru_r     <= bus.lru;
                        beat_cnt  <= '0;
                        err       <= 1'b0;
                        arvalid_r <= 1'b1;
                        state     <= AR;
                    end
                end
                AR: begin
                    if (bus.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (bus.rvalid) begin
                        // Beats past the line width are drained but never stored.
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                line_buf[k*AXI_DATA_W +: AXI_DATA_W] <= bus.rdata;
                            end
                        end
                        if (beat_cnt != CNT_W'(BEATS)) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        err <= burst_err;
                        if (bus.rlast) begin
                            rready_r  <= 1'b0;
                            refresh_r <= ~burst_err;
                            fault_r   <= burst_err;
                            state     <= WR;
                        end
                    end
                end
                WR:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - randomized scoreboard bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
    localparam int LINE_W     = 64;
    localparam int AXI_DATA_W = 32;
    localparam int INDEX_W    = 6;
    localparam int OFFSET_W   = 3;
    localparam int TAG_W      = 55;
    localparam int BEATS      = LINE_W / AXI_DATA_W;

    typedef struct {
        logic               way;
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [LINE_W-1:0]  line;
        logic               flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [63:0] exp_araddr = '0;

    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.LINE_W(LINE_W), .AXI_DATA_W(AXI_DATA_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    icache_refill_ctrl #(
        .LINE_W(LINE_W), .AXI_DATA_W(AXI_DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every refresh/fault pops one expected refill outcome.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.refresh || bus.fault) begin
                    if (sb.size() == 0) begin
                        check("unexpected_refill", {bus.refresh, bus.fault}, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        check("fault", bus.fault, e.flt);
                        check("refresh", bus.refresh, !e.flt);
                        if (!e.flt) begin
                            check("refill_way", bus.refill_way, e.way);
                            check("refill_index", bus.refill_index, e.index);
                            check("refill_tag", bus.refill_tag, e.tag);
                            check("cacheline_new", bus.cacheline_new, e.line);
                        end
                    end
                end
                if (bus.arvalid) begin
                    check("araddr", bus.araddr, exp_araddr);
                    check("arlen", bus.arlen, BEATS - 1);
                    check("arsize", bus.arsize, 2);
                    check("arburst", bus.arburst, 2'b01);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid = (i % 3 != 2);
            bus.req_addr  = {$urandom, $urandom};
            bus.hit       = bus.req_valid ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.lru       = 1'($urandom);
            @(negedge clk);
            check("hit_stall", bus.stall, 1'b0);
            check("hit_arvalid", bus.arvalid, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.hit       = 2'b00;
    endtask

    // mode: 0 normal burst, 1 early rlast on beat 0, 2 rlast missing on the final beat (one extra beat carries it)
    task automatic refill(input logic [63:0] addr, input logic way, input int ar_wait, input int gap,
                          input int mode, input logic bad_resp, input logic do_rst,
                          input logic [AXI_DATA_W-1:0] w0, input logic [AXI_DATA_W-1:0] w1);
        logic [AXI_DATA_W-1:0] words [BEATS+1];
        logic [LINE_W-1:0]     line;
        exp_t                  e;
        int                    nbeats, lat, stalled, ar_seen, b, idle;
        logic                  fin;

        nbeats = (mode == 1) ? 1 : (mode == 2) ? BEATS + 1 : BEATS;
        line   = '0;
        for (int i = 0; i <= BEATS; i++) begin
            words[i] = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
            if (i < BEATS) line |= LINE_W'(words[i]) << (AXI_DATA_W * i);
        end
        e.way      = way;
        e.index    = INDEX_W'((addr >> OFFSET_W) % (64'd1 << INDEX_W));
        e.tag      = TAG_W'(addr >> (OFFSET_W + INDEX_W));
        e.line     = line;
        e.flt      = bad_resp || (mode != 0);
        lat        = (ar_wait + 1) + nbeats + gap * (nbeats - 1) + 2;
        exp_araddr = (addr >> OFFSET_W) << OFFSET_W;
        if (!do_rst) sb.push_back(e);

        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.hit       = 2'b00;
        bus.lru       = way;
        stalled = 0; ar_seen = 0; b = 0; idle = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            if (do_rst && b == 1) begin
                rst = 1'b1; bus.req_valid = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.arready = 1'b0;
                @(negedge clk);
                check("abort_ctrl_outputs", {bus.stall, bus.arvalid, bus.rready, bus.refresh, bus.fault}, 5'b0);
                check("abort_araddr", bus.araddr, 64'h0);
                check("abort_line", bus.cacheline_new, 64'h0);
                rst = 1'b0;
                return;
            end
            if (bus.stall) stalled++;
            else fin = 1'b1;
            if (bus.arvalid || bus.rready) begin
                bus.req_addr = {$urandom, $urandom};
                bus.lru      = 1'($urandom);
            end
            if (bus.arvalid) begin
                ar_seen++;
                bus.arready = (ar_seen > ar_wait);
            end else begin
                bus.arready = 1'b0;
            end
            bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00; bus.rdata = $urandom;
            if (bus.rready && b < nbeats) begin
                if (idle > 0) begin
                    idle--;
                end else begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = words[b];
                    bus.rresp  = (bad_resp && b == 0) ? 2'b10 : 2'b00;
                    bus.rlast  = (mode == 1) ? (b == 0) : (b == nbeats - 1);
                    b++;
                    idle = gap;
                end
            end
            if (bus.refresh) begin
                bus.req_addr = addr;
                bus.lru      = way;
                bus.hit      = 2'b01 << way;
            end
            if (bus.fault) bus.req_valid = 1'b0;
        end
        check("miss_latency", stalled, lat);
        check("ar_cycles", ar_seen, ar_wait + 1);
        bus.req_valid = 1'b0; bus.hit = 2'b00; bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.hit = 2'b00; bus.lru = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl_outputs", {bus.stall, bus.arvalid, bus.rready, bus.refresh, bus.fault}, 5'b0);
        check("rst_araddr", bus.araddr, 64'h0);
        check("rst_line", bus.cacheline_new, 64'h0);
        check("rst_refill_fields", {bus.refill_way, bus.refill_index, bus.refill_tag}, 0);
        check("rst_arlen", bus.arlen, 8'd1);
        check("rst_arsize", bus.arsize, 3'd2);
        check("rst_arburst", bus.arburst, 2'b01);
        rst = 1'b0;
        @(negedge clk);

        hits(9);
        refill(64'h8000_0048, 1'b1, 0, 0, 0, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        refill({$urandom, $urandom}, 1'b0, 3, 0, 0, 1'b0, 1'b0, $urandom, $urandom);
        refill({$urandom, $urandom}, 1'b1, 0, 2, 0, 1'b0, 1'b0, $urandom, $urandom);
        refill({$urandom, $urandom}, 1'b0, 0, 0, 0, 1'b1, 1'b0, $urandom, $urandom);
        refill({$urandom, $urandom}, 1'b1, 1, 0, 0, 1'b0, 1'b1, $urandom, $urandom);
        @(negedge clk);
        refill(64'h8000_0048, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'hCAFE_0001, 32'hBEEF_0002);
        refill({$urandom, $urandom}, 1'b1, 0, 0, 1, 1'b0, 1'b0, $urandom, $urandom);
        refill({$urandom, $urandom}, 1'b0, 2, 1, 2, 1'b0, 1'b0, $urandom, $urandom);

        for (int t = 0; t < 30; t++) begin
            int m;
            m = $urandom_range(0, 5);
            refill({$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                   (m == 4) ? 1 : (m == 5) ? 2 : 0, ($urandom_range(0, 5) == 0), 1'b0, $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) hits($urandom_range(1, 4));
        end
        hits(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
